// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: pops the receiver FIFO, folds E0/F0 prefixes into key events.
// Optional auto-repeat suppression is enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_key_ctrl #(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TMO_W       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    output logic       kbd_rd_n,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       key_held,
    output logic [8:0] held_code,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {S_IDLE, S_POP, S_DECODE, S_EMIT} state_t;

    state_t           state_reg, state_next;
    logic [7:0]       byte_reg, byte_next;
    logic             ext_flag_reg, ext_flag_next;
    logic             brk_flag_reg, brk_flag_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             kbd_rd_n_next;
    logic             evt_valid_next, evt_ext_next, evt_brk_next;
    logic [7:0]       evt_code_next;
    logic             key_held_next;
    logic [8:0]       held_code_next;
    logic [7:0]       press_count_next;
    logic             flag_any;
    logic             is_nonkey;

    assign flag_any = ext_flag_reg | brk_flag_reg;

    // Device responses (BAT ok, echo, ack, resend, errors) are not key codes
    always_comb begin
        is_nonkey = 1'b0;
        case (byte_reg)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_nonkey = 1'b1;
            default:                                 is_nonkey = 1'b0;
        endcase
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic is_repeat;
    assign is_repeat = !brk_flag_reg && key_held && ({ext_flag_reg, byte_reg} == held_code);
`endif

    always_comb begin
        state_next       = state_reg;
        byte_next        = byte_reg;
        ext_flag_next    = ext_flag_reg;
        brk_flag_next    = brk_flag_reg;
        tmo_cnt_next     = flag_any ? tmo_cnt_reg : '0;
        evt_valid_next   = evt_valid;
        evt_code_next    = evt_code;
        evt_ext_next     = evt_ext;
        evt_brk_next     = evt_brk;
        key_held_next    = key_held;
        held_code_next   = held_code;
        press_count_next = press_count;

        case (state_reg)
            S_IDLE: begin
                // Expiry is checked even when a byte arrives, so that byte decodes with clean flags
                if (flag_any) begin
                    if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
                        ext_flag_next = 1'b0;
                        brk_flag_next = 1'b0;
                        tmo_cnt_next  = '0;
                    end else if (!kbd_ready) begin
                        tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                    end
                end
                if (kbd_ready) begin
                    byte_next  = kbd_data;
                    state_next = S_POP;
                end
            end
            S_POP: state_next = S_DECODE;
            S_DECODE: begin
                state_next = S_IDLE;
                if (byte_reg == 8'hE0) begin
                    ext_flag_next = 1'b1;
                    tmo_cnt_next  = '0;
                end else if (byte_reg == 8'hF0) begin
                    brk_flag_next = 1'b1;
                    tmo_cnt_next  = '0;
                end else if (is_nonkey) begin
                    ext_flag_next = 1'b0;
                    brk_flag_next = 1'b0;
                    tmo_cnt_next  = '0;
                end
`ifdef PS2_TYPEMATIC_FILTER_EN
                else if (is_repeat) begin
                    ext_flag_next = 1'b0;
                    brk_flag_next = 1'b0;
                    tmo_cnt_next  = '0;
                end
`endif
                else begin
                    evt_code_next  = byte_reg;
                    evt_ext_next   = ext_flag_reg;
                    evt_brk_next   = brk_flag_reg;
                    evt_valid_next = 1'b1;
                    state_next     = S_EMIT;
                end
            end
            S_EMIT: begin
                if (evt_ready) begin
                    evt_valid_next = 1'b0;
                    ext_flag_next  = 1'b0;
                    brk_flag_next  = 1'b0;
                    tmo_cnt_next   = '0;
                    state_next     = S_IDLE;
                    if (!evt_brk) begin
                        key_held_next    = 1'b1;
                        held_code_next   = {evt_ext, evt_code};
                        press_count_next = press_count + 8'd1;
                    end else if (key_held && ({evt_ext, evt_code} == held_code)) begin
                        key_held_next = 1'b0;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Strobe is registered from the next state so it is low exactly while in S_POP
    assign kbd_rd_n_next = (state_next != S_POP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            byte_reg     <= 8'h00;
            ext_flag_reg <= 1'b0;
            brk_flag_reg <= 1'b0;
            tmo_cnt_reg  <= '0;
            kbd_rd_n     <= 1'b1;
            evt_valid    <= 1'b0;
            evt_code     <= 8'h00;
            evt_ext      <= 1'b0;
            evt_brk      <= 1'b0;
            key_held     <= 1'b0;
            held_code    <= 9'h000;
            press_count  <= 8'h00;
        end else begin
            state_reg    <= state_next;
            byte_reg     <= byte_next;
            ext_flag_reg <= ext_flag_next;
            brk_flag_reg <= brk_flag_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            kbd_rd_n     <= kbd_rd_n_next;
            evt_valid    <= evt_valid_next;
            evt_code     <= evt_code_next;
            evt_ext      <= evt_ext_next;
            evt_brk      <= evt_brk_next;
            key_held     <= key_held_next;
            held_code    <= held_code_next;
            press_count  <= press_count_next;
        end
    end

endmodule
